// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon sequence controller.
// Imported by the top level and the sequence memory.
package simon_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_ADD,
    S_SHOW,
    S_SHOW_ON,
    S_GAP,
    S_NEXT,
    S_INPUT,
    S_HOLD,
    S_WIN,
    S_LOSE
  } state_e;

  function automatic int color_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: one synchronous write port and a
// combinational read port.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int NUM_COLORS = 4,
  parameter int DEPTH      = 32,
  localparam int COLOR_W   = color_w(NUM_COLORS),
  localparam int AW        = addr_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  logic [COLOR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_seq_controller.sv
// Simon game controller: grows a random colour sequence, replays it,
// then checks the player's presses with optional timeout.
module simon_seq_controller
  import simon_pkg::*;
#(
  parameter int NUM_COLORS    = 4,
  parameter int DEPTH         = 32,
  parameter int TIMEOUT_TICKS = 8,
  localparam int COLOR_W      = color_w(NUM_COLORS),
  localparam int CNT_W        = cnt_w(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COLOR_W-1:0] IN,
  input  logic               IN_VALID,
  input  logic [COLOR_W-1:0] RAND,
  input  logic               START_GAME,
  input  logic               FAST,
  input  logic               TIMER_PULSE,
  output logic               TIMER_GO,
  output logic [COLOR_W-1:0] OUT,
  output logic               OUT_ENA,
  output logic               WIN,
  output logic               LOSE,
  output logic               HS,
  output logic [CNT_W-1:0]   SCORE,
  output logic [CNT_W-1:0]   HIGH_SCORE
);

  localparam int AW    = addr_w(DEPTH);
  localparam int TMO_W = cnt_w(TIMEOUT_TICKS);

  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0]   TMO_C   = TMO_W'(TIMEOUT_TICKS);
  localparam logic [COLOR_W-1:0] OUT_RST = COLOR_W'(NUM_COLORS - 1);
  localparam logic [COLOR_W:0]   NC_EXT  = (COLOR_W + 1)'(NUM_COLORS);

  state_e state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               good_q, good_d;
  logic [COLOR_W-1:0] out_q, out_d;
  logic               ena_q, ena_d;
  logic               go_q, go_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               hs_q, hs_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   high_q, high_d;

  logic               mem_we;
  logic [COLOR_W-1:0] rdata;
  logic [COLOR_W-1:0] rand_fold;
  logic               last;

  // RAND spans at most 2*NUM_COLORS values, so one subtract folds it
  assign rand_fold = ({1'b0, RAND} >= NC_EXT)
                   ? RAND - NC_EXT[COLOR_W-1:0] : RAND;
  assign last = (idx_q == len_q - 1'b1);

  simon_seq_mem #(
    .NUM_COLORS(NUM_COLORS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .CLK    (CLK),
    .we_i   (mem_we),
    .waddr_i(len_q[AW-1:0]),
    .wdata_i(rand_fold),
    .raddr_i(idx_q[AW-1:0]),
    .rdata_o(rdata)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    good_d  = good_q;
    out_d   = out_q;
    ena_d   = ena_q;
    go_d    = 1'b0;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    hs_d    = 1'b0;
    score_d = score_q;
    high_d  = high_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        len_d = '0;
        if (START_GAME) state_d = S_ARM;
      end
      S_ARM: begin
        score_d = '0;
        if (!START_GAME) state_d = S_ADD;
      end
      S_ADD: begin
        if (len_q != DEPTH_C) begin
          mem_we = 1'b1;
          len_d  = len_q + 1'b1;
        end
        state_d = S_SHOW;
      end
      S_SHOW: begin
        out_d   = rdata;
        ena_d   = 1'b1;
        go_d    = 1'b1;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (TIMER_PULSE) begin
          ena_d = 1'b0;
          if (FAST) begin
            state_d = S_NEXT;
          end else begin
            go_d    = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (TIMER_PULSE) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (last) begin
          idx_d   = '0;
          tmo_d   = '0;
          go_d    = 1'b1;
          state_d = S_INPUT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SHOW;
        end
      end
      S_INPUT: begin
        if (IN_VALID) begin
          good_d  = (IN == rdata);
          out_d   = IN;
          ena_d   = 1'b1;
          state_d = S_HOLD;
        end else if (TIMER_PULSE && TIMEOUT_TICKS != 0) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_C) state_d = S_LOSE;
        end
      end
      S_HOLD: begin
        if (!IN_VALID) begin
          ena_d = 1'b0;
          if (!good_q) begin
            state_d = S_LOSE;
          end else if (last) begin
            score_d = len_q;
            if (len_q == DEPTH_C) begin
              state_d = S_WIN;
            end else begin
              idx_d   = '0;
              state_d = S_ADD;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tmo_d   = '0;
            go_d    = 1'b1;
            state_d = S_INPUT;
          end
        end
      end
      S_WIN, S_LOSE: begin
        win_d   = (state_q == S_WIN);
        lose_d  = (state_q == S_LOSE);
        hs_d    = (score_q > high_q);
        if (score_q > high_q) high_d = score_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      good_q  <= 1'b0;
      out_q   <= OUT_RST;
      ena_q   <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      hs_q    <= 1'b0;
      score_q <= '0;
      high_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      good_q  <= good_d;
      out_q   <= out_d;
      ena_q   <= ena_d;
      go_q    <= go_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      hs_q    <= hs_d;
      score_q <= score_d;
      high_q  <= high_d;
    end
  end

  assign TIMER_GO   = go_q;
  assign OUT        = out_q;
  assign OUT_ENA    = ena_q;
  assign WIN        = win_q;
  assign LOSE       = lose_q;
  assign HS         = hs_q;
  assign SCORE      = score_q;
  assign HIGH_SCORE = high_q;

endmodule
